// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : framed UART byte stream -> 32-bit instruction-memory writes
// Rev 1.0
// ============================================================================
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter int          ADDR_W    = 5,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    GET_COUNT = 3'd1,
    GET_DATA  = 3'd2,
    GET_CSUM  = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         word_q, word_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [7:0]          csum_q, csum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [CNT_W-1:0]    words_inc;
  logic                is_sync;
  logic                count_ok;

  assign words_inc = words_q + 1'b1;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign count_ok  = (rx_data != 8'd0) && (32'(rx_data) <= DEPTH);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    count_d = count_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    words_d = words_q;

    // Post-write bookkeeping; address stops at the last word so it never leaves 0..DEPTH-1
    if (we_q) begin
      words_d = words_inc;
      if (words_inc < count_q) begin
        waddr_d = waddr_q + 1'b1;
      end
    end

    if (rx_valid) begin
      case (state_q)
        WAIT_SYNC, DONE, ERROR: begin
          if (is_sync) begin
            state_d = GET_COUNT;
            csum_d  = 8'd0;
            lane_d  = 2'd0;
            words_d = '0;
            waddr_d = '0;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        GET_COUNT: begin
          if (count_ok) begin
            count_d = CNT_W'(rx_data);
            state_d = GET_DATA;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
        GET_DATA: begin
          csum_d = csum_q ^ rx_data;
          lane_d = lane_q + 2'd1;
          word_d = {rx_data, word_q[31:8]};
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {rx_data, word_q[31:8]};
            // words_q is already up to date: the previous write was at least 4 strobes ago
            if (words_inc == count_q) begin
              state_d = GET_CSUM;
            end
          end
        end
        GET_CSUM: begin
          if (rx_data == csum_q) begin
            state_d = DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      lane_q  <= 2'd0;
      word_q  <= 32'd0;
      count_q <= '0;
      csum_q  <= 8'd0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_hold    = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : scoreboard bench for imem_loader
// Rev 1.0
// ============================================================================
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %08h, expected none", imem_waddr, imem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(imem_waddr), 64'(e.addr));
        chk("wr_data", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_prog;
    push_wr(5'd0, 32'h00500093);
    push_wr(5'd1, 32'h00500113);
    push_wr(5'd2, 32'h00208463);
  endtask

  task automatic status(input string tag, input logic d, input logic e, input logic h, input int w);
    @(negedge clk);
    chk({tag, "_done"}, 64'(load_done), 64'(d));
    chk({tag, "_err"},  64'(load_err),  64'(e));
    chk({tag, "_hold"}, 64'(core_hold), 64'(h));
    chk({tag, "_words"}, 64'(words_loaded), 64'(w));
    chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  logic [7:0] prog [15];
  logic [7:0] garb [3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    prog = '{8'hA5, 8'h03, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01,
             8'h50, 8'h00, 8'h63, 8'h84, 8'h20, 8'h00, 8'h46};
    garb = '{8'h00, 8'hFF, 8'h13};
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold",  64'(core_hold), 64'd1);
    chk("rst_done",  64'(load_done), 64'd0);
    chk("rst_err",   64'(load_err),  64'd0);
    chk("rst_we",    64'(imem_we),   64'd0);
    chk("rst_waddr", 64'(imem_waddr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Good 3-word frame, back-to-back strobes
    push_prog();
    for (int i = 0; i < 15; i++) send(prog[i], 0);
    status("good", 1'b1, 1'b0, 1'b0, 3);

    // Bad checksum: writes still happen, frame rejected
    push_prog();
    for (int i = 0; i < 14; i++) send(prog[i], 1);
    send(8'h47, 0);
    status("badcs", 1'b0, 1'b1, 1'b1, 3);

    push_prog();
    for (int i = 0; i < 15; i++) send(prog[i], 0);
    status("recover", 1'b1, 1'b0, 1'b0, 3);

    // Invalid counts
    send(8'hA5, 0);
    send(8'h00, 0);
    status("cnt00", 1'b0, 1'b1, 1'b1, 0);
    send(8'hA5, 2);
    send(8'h21, 0);
    send(8'h93, 0);
    status("cnt21", 1'b0, 1'b1, 1'b1, 0);

    // Leading garbage and idle gaps of 0..5 cycles
    push_prog();
    for (int i = 0; i < 3; i++) send(garb[i], i);
    for (int i = 0; i < 15; i++) send(prog[i], i % 6);
    status("gaps", 1'b1, 1'b0, 1'b0, 3);

    // Reset after the 6th data byte
    push_wr(5'd0, 32'h00500093);
    for (int i = 0; i < 8; i++) send(prog[i], 0);
    @(negedge clk);
    chk("midrst_one_write", 64'(sb.size()), 64'd0);
    rst = 1'b1;
    #1;
    chk("midrst_hold",  64'(core_hold), 64'd1);
    chk("midrst_done",  64'(load_done), 64'd0);
    chk("midrst_err",   64'(load_err),  64'd0);
    chk("midrst_we",    64'(imem_we),   64'd0);
    chk("midrst_waddr", 64'(imem_waddr), 64'd0);
    chk("midrst_wdata", 64'(imem_wdata), 64'd0);
    chk("midrst_words", 64'(words_loaded), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_prog();
    for (int i = 0; i < 15; i++) send(prog[i], 0);
    status("afterrst", 1'b1, 1'b0, 1'b0, 3);

    // Full-depth frame of A5 data bytes; XOR of 128 A5 bytes is 00
    for (int i = 0; i < DEPTH; i++) push_wr(ADDR_W'(i), 32'hA5A5A5A5);
    send(8'hA5, 0);
    send(8'h20, 0);
    for (int i = 0; i < 4 * DEPTH; i++) send(8'hA5, 0);
    send(8'h00, 0);
    status("full", 1'b1, 1'b0, 1'b0, DEPTH);
    chk("full_last_waddr", 64'(imem_waddr), 64'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
